// File: rtl/la_capture_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : la_capture_controller_pkg
// Brief    : Shared state encodings and defaults for the LA capture block.
// Revision : 1.0  initial release
// ============================================================================
package la_capture_controller_pkg;

    localparam int LA_DEFAULT_ADDR_WIDTH = 10;

    localparam logic [1:0] LA_CAP_IDLE      = 2'd0;
    localparam logic [1:0] LA_CAP_ARMED     = 2'd1;
    localparam logic [1:0] LA_CAP_TRIGGERED = 2'd2;
    localparam logic [1:0] LA_CAP_DONE      = 2'd3;

endpackage
`default_nettype wire

// File: rtl/la_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module   : la_capture_buffer
// Brief    : Simple dual-port sample RAM, one write port, one registered read.
// Revision : 1.0  initial release
// ============================================================================
module la_capture_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int c_depth = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:c_depth-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Only the output register is reset; the array keeps its contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_rdata <= '0;
        end else begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/la_capture_controller.sv
`default_nettype none
// ============================================================================
// Module   : la_capture_controller
// Brief    : Masked/qualified trigger, circular pre/post capture, strobed readout.
// Revision : 1.0  initial release
// ============================================================================
module la_capture_controller
    import la_capture_controller_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = LA_DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_strobe,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] trigger,
    input  logic [DATA_WIDTH-1:0] trigger_mask,
    input  logic [31:0]           trigger_after,
    input  logic [31:0]           repeat_count,
    input  logic [DATA_WIDTH-1:0] cap_data,
    output logic                  finished,
    output logic [31:0]           data_read_size,
    input  logic                  data_read_strobe,
    output logic [DATA_WIDTH-1:0] data
);

    localparam logic [ADDR_WIDTH:0] c_fill_full = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [31:0]         c_after_max = 32'((1 << ADDR_WIDTH) - 1);

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_trig_s;
    logic [DATA_WIDTH-1:0] r_mask_s;
    logic [31:0]           r_after_s;
    logic [31:0]           r_rep_s;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_fill;
    logic [31:0]           r_run;
    logic [31:0]           r_post;
    logic                  r_finished;
    logic [31:0]           r_size;

    logic                  w_match;
    logic [31:0]           w_after_eff;
    logic                  w_trig_hit;
    logic                  w_write;
    logic                  w_strobe_ok;
    logic [ADDR_WIDTH-1:0] w_rd_start;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [1:0]            w_next_state;

    assign w_match     = ((cap_data ^ r_trig_s) & r_mask_s) == '0;
    assign w_after_eff = (r_after_s > c_after_max) ? c_after_max : r_after_s;
    assign w_trig_hit  = (r_state == LA_CAP_ARMED) && w_match && (r_run == r_rep_s);
    assign w_write     = (r_state == LA_CAP_ARMED) || (r_state == LA_CAP_TRIGGERED);
    assign w_rd_start  = (r_fill == c_fill_full) ? r_wr_ptr : '0;
    assign w_strobe_ok = (r_state == LA_CAP_DONE) && r_finished && data_read_strobe
                         && (r_size != 32'd0);

    // Read address runs one step ahead so data follows a strobe by one cycle.
    always_comb begin
        w_raddr = r_rd_ptr;
        if ((r_state == LA_CAP_DONE) && !r_finished) begin
            w_raddr = w_rd_start;
        end else if (w_strobe_ok) begin
            w_raddr = r_rd_ptr + 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LA_CAP_IDLE:      if (enable) w_next_state = LA_CAP_ARMED;
            LA_CAP_ARMED:     if (w_trig_hit) w_next_state = (w_after_eff == 32'd0) ? LA_CAP_DONE
                                                                                     : LA_CAP_TRIGGERED;
            LA_CAP_TRIGGERED: if (r_post == 32'd1) w_next_state = LA_CAP_DONE;
            default:          w_next_state = r_state;
        endcase
        if (!enable || (set_strobe && (r_state != LA_CAP_IDLE))) begin
            w_next_state = LA_CAP_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= LA_CAP_IDLE;
            r_trig_s   <= '0;
            r_mask_s   <= '0;
            r_after_s  <= '0;
            r_rep_s    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_run      <= '0;
            r_post     <= '0;
            r_finished <= 1'b0;
            r_size     <= '0;
        end else begin
            r_state <= w_next_state;
            if (set_strobe) begin
                r_trig_s  <= trigger;
                r_mask_s  <= trigger_mask;
                r_after_s <= trigger_after;
                r_rep_s   <= repeat_count;
            end
            case (r_state)
                LA_CAP_IDLE: begin
                    r_wr_ptr   <= '0;
                    r_fill     <= '0;
                    r_run      <= '0;
                    r_finished <= 1'b0;
                    r_size     <= '0;
                end
                LA_CAP_ARMED, LA_CAP_TRIGGERED: begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (r_fill != c_fill_full) r_fill <= r_fill + 1'b1;
                    if (!w_match)              r_run  <= '0;
                    else if (r_run != '1)      r_run  <= r_run + 32'd1;
                    if (w_trig_hit)                        r_post <= w_after_eff;
                    else if (r_state == LA_CAP_TRIGGERED)  r_post <= r_post - 32'd1;
                end
                default: begin
                    if (!r_finished) begin
                        r_finished <= 1'b1;
                        r_size     <= 32'(r_fill);
                        r_rd_ptr   <= w_rd_start;
                    end else if (w_strobe_ok) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        r_size   <= r_size - 32'd1;
                    end
                end
            endcase
            if (w_next_state == LA_CAP_IDLE) begin
                r_finished <= 1'b0;
                r_size     <= '0;
            end
        end
    end

    la_capture_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_buffer (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_write),
        .i_waddr (r_wr_ptr),
        .i_wdata (cap_data),
        .i_raddr (w_raddr),
        .o_rdata (data)
    );

    assign finished       = r_finished;
    assign data_read_size = r_size;

endmodule
`default_nettype wire

// File: tb/tb_la_capture_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_la_capture_controller
// Brief    : Randomized self-checking bench with a sample-list reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_la_capture_controller;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          set_strobe;
    logic          enable;
    logic [DW-1:0] trigger;
    logic [DW-1:0] trigger_mask;
    logic [31:0]   trigger_after;
    logic [31:0]   repeat_count;
    logic [DW-1:0] cap_data;
    logic          finished;
    logic [31:0]   data_read_size;
    logic          data_read_strobe;
    logic [DW-1:0] data;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   smp [0:8191];
    logic [31:0]   exp_words [$];
    int            exp_size;

    always #5 clk = ~clk;

    la_capture_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .set_strobe       (set_strobe),
        .enable           (enable),
        .trigger          (trigger),
        .trigger_mask     (trigger_mask),
        .trigger_after    (trigger_after),
        .repeat_count     (repeat_count),
        .cap_data         (cap_data),
        .finished         (finished),
        .data_read_size   (data_read_size),
        .data_read_strobe (data_read_strobe),
        .data             (data)
    );

    // Reference: trigger is the first sample closing a run of rep+1 matches;
    // the buffer keeps the newest min(total, DEPTH) samples ending after_eff later.
    function automatic int model(input logic [31:0] trg, input logic [31:0] msk,
                                 input logic [31:0] aft, input logic [31:0] rep, input int n);
        int run_len = 0;
        int t = -1;
        int after_eff;
        int total;
        for (int k = 0; k < n; k++) begin
            if (((smp[k] ^ trg) & msk) == 32'd0) run_len++;
            else run_len = 0;
            if (32'(run_len) > rep) begin
                t = k;
                break;
            end
        end
        after_eff = (aft > 32'(DEPTH - 1)) ? DEPTH - 1 : int'(aft);
        total     = t + after_eff + 1;
        exp_size  = (total > DEPTH) ? DEPTH : total;
        exp_words.delete();
        for (int k = total - exp_size; k < total; k++) exp_words.push_back(smp[k]);
        return (t < 0) ? -1 : total;
    endfunction

    task automatic arm(input logic [31:0] trg, input logic [31:0] msk,
                       input logic [31:0] aft, input logic [31:0] rep, input bit keep_enable);
        @(negedge clk);
        enable        = keep_enable;
        set_strobe    = 1'b1;
        trigger       = trg;
        trigger_mask  = msk;
        trigger_after = aft;
        repeat_count  = rep;
        @(negedge clk);
        set_strobe    = 1'b0;
        enable        = 1'b1;
        // live config changes after latching must not matter
        trigger       = $urandom;
        trigger_mask  = $urandom;
        trigger_after = $urandom;
        repeat_count  = $urandom;
    endtask

    task automatic feed_and_wait(input int n, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cap_data = smp[k];
        end
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            cap_data = $urandom;
            seen = finished;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s finished: got %0b want 1 (timeout)", name, finished);
        end
    endtask

    task automatic read_all(input string name);
        checks++;
        if (data_read_size !== 32'(exp_size)) begin
            errors++;
            $display("FAIL %s size: got %0d want %0d", name, data_read_size, exp_size);
        end
        for (int i = 0; i < exp_size; i++) begin
            checks++;
            if (data !== exp_words[i]) begin
                errors++;
                $display("FAIL %s word[%0d]: got %h want %h", name, i, data, exp_words[i]);
            end
            data_read_strobe = 1'b1;
            @(negedge clk);
        end
        data_read_strobe = 1'b0;
        checks++;
        if (data_read_size !== 32'd0 || finished !== 1'b1) begin
            errors++;
            $display("FAIL %s drained: got size %0d fin %0b want size 0 fin 1",
                     name, data_read_size, finished);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (finished !== 1'b0 || data_read_size !== 32'd0 || data !== 32'd0) begin
            errors++;
            $display("FAIL reset: got fin %0b size %0d data %h want 0 0 0",
                     finished, data_read_size, data);
        end
        rst = 1'b0;
    endtask

    task automatic test_ramp();
        int total;
        for (int k = 0; k < 400; k++) smp[k] = 32'(k);
        total = model(32'h0000_00A5, 32'hFFFF_FFFF, 32'd3, 32'd0, 400);
        arm(32'h0000_00A5, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b0);
        feed_and_wait(total, "ramp");
        checks++;
        if (data_read_size !== 32'hA9 || data !== 32'h0) begin
            errors++;
            $display("FAIL ramp first: got size %h data %h want a9 0", data_read_size, data);
        end
        read_all("ramp");
    endtask

    task automatic test_clamp_and_extra_strobes();
        int total;
        for (int k = 0; k < DEPTH + 40; k++) smp[k] = $urandom;
        total = model($urandom, 32'h0, 32'(DEPTH + 5), 32'd0, DEPTH + 40);
        arm($urandom, 32'h0, 32'(DEPTH + 5), 32'd0, 1'b0);
        feed_and_wait(total, "clamp");
        read_all("clamp");
        // full buffer: read pointer wraps back onto the oldest sample
        for (int i = 0; i < 3; i++) begin
            data_read_strobe = 1'b1;
            @(negedge clk);
            data_read_strobe = 1'b0;
            checks++;
            if (data !== exp_words[0] || data_read_size !== 32'd0 || finished !== 1'b1) begin
                errors++;
                $display("FAIL extra_strobe: got data %h size %0d fin %0b want %h 0 1",
                         data, data_read_size, finished, exp_words[0]);
            end
        end
    endtask

    task automatic test_repeat();
        logic [31:0] p;
        logic [31:0] v;
        int total;
        p = $urandom;
        for (int k = 0; k < 60; k++) begin
            do v = $urandom; while (v == p);
            smp[k] = v;
        end
        smp[10] = p; smp[11] = p;
        smp[13] = p; smp[14] = p; smp[15] = p;
        total = model(p, 32'hFFFF_FFFF, 32'd4, 32'd2, 60);
        arm(p, 32'hFFFF_FFFF, 32'd4, 32'd2, 1'b0);
        feed_and_wait(total, "repeat");
        checks++;
        if (data_read_size !== 32'd20) begin
            errors++;
            $display("FAIL repeat size: got %0d want 20", data_read_size);
        end
        read_all("repeat");
    endtask

    task automatic test_wrap();
        logic [31:0] base;
        int total;
        base = $urandom_range(0, 32'h0FFF_FFFF);
        for (int k = 0; k < 5100; k++) smp[k] = base + 32'(k);
        total = model(base + 32'd5000, 32'hFFFF_FFFF, 32'd10, 32'd0, 5100);
        arm(base + 32'd5000, 32'hFFFF_FFFF, 32'd10, 32'd0, 1'b0);
        feed_and_wait(total, "wrap");
        checks++;
        if (data !== base + 32'd5010 - 32'(DEPTH - 1)) begin
            errors++;
            $display("FAIL wrap oldest: got %h want %h", data, base + 32'd5010 - 32'(DEPTH - 1));
        end
        read_all("wrap");
    endtask

    task automatic test_random();
        logic [31:0] trg, msk, aft, rep;
        int total;
        for (int it = 0; it < 5; it++) begin
            trg = $urandom;
            msk = $urandom & $urandom & $urandom;
            rep = $urandom_range(0, 3);
            aft = (it == 0) ? 32'd0 : $urandom_range(0, 20);
            for (int k = 0; k < 320; k++) begin
                smp[k] = $urandom;
                if ($urandom_range(0, 2) == 0 || (k >= 250 && k <= 253))
                    smp[k] = (trg & msk) | (smp[k] & ~msk);
            end
            total = model(trg, msk, aft, rep, 320);
            arm(trg, msk, aft, rep, 1'b0);
            feed_and_wait(total, "random");
            read_all("random");
        end
    endtask

    task automatic test_abort_and_rearm();
        logic [31:0] x, y;
        int total;
        // drop enable while post-trigger samples are still being taken
        for (int k = 0; k < 20; k++) smp[k] = $urandom;
        arm(32'h0, 32'h0, 32'd50, 32'd0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            cap_data = smp[k];
        end
        enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (finished !== 1'b0 || data_read_size !== 32'd0) begin
                errors++;
                $display("FAIL abort: got fin %0b size %0d want 0 0", finished, data_read_size);
            end
        end
        // reset in the middle of a readout
        for (int k = 0; k < 400; k++) smp[k] = 32'(k) ^ 32'h5A00_0000;
        total = model(32'h5A00_0020, 32'hFFFF_FFFF, 32'd2, 32'd0, 400);
        arm(32'h5A00_0020, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0);
        feed_and_wait(total, "rst_mid");
        for (int i = 0; i < 5; i++) begin
            data_read_strobe = 1'b1;
            @(negedge clk);
        end
        data_read_strobe = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (finished !== 1'b0 || data_read_size !== 32'd0 || data !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid: got fin %0b size %0d data %h want 0 0 0",
                     finished, data_read_size, data);
        end
        // set_strobe while armed restarts with the new trigger
        x = 32'hDEAD_0000 | $urandom_range(0, 255);
        y = 32'hBEEF_0000 | $urandom_range(0, 255);
        for (int k = 0; k < 30; k++) smp[k] = y;
        arm(x, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            cap_data = smp[k];
        end
        for (int k = 0; k < 40; k++) smp[k] = 32'h1000_0000 + 32'(k);
        smp[7] = y;
        total = model(y, 32'hFFFF_FFFF, 32'd2, 32'd0, 40);
        arm(y, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b1);
        feed_and_wait(total, "rearm");
        read_all("rearm");
    endtask

    initial begin
        rst = 1'b1; set_strobe = 1'b0; enable = 1'b0; data_read_strobe = 1'b0;
        trigger = '0; trigger_mask = '0; trigger_after = '0; repeat_count = '0; cap_data = '0;
        test_reset();
        test_ramp();
        test_clamp_and_extra_strobes();
        test_repeat();
        test_wrap();
        test_random();
        test_abort_and_rearm();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
